snr_measure_sequencer: RTL and testbench

Sequences the mic → decimator → SNR calculator chain for one measurement session. The session runs settle, then noise calibration (drives the calculator's quiet_period), then continuous measurement. In measurement it block-averages snr_db into a display-rate result. Sits between the decimator/SNR calculator and the seven-segment/LED logic in the top level. It replaces manual KEY-held calibration and the free-running display counter.

---
 rtl/snr_measure_sequencer.sv | 132 +++++++++++++
 tb/tb_snr_measure_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snr_measure_sequencer.sv
// snr_measure_sequencer: runs settle -> noise calibration -> measurement for one SNR session,
// block-averages snr_db for display and trips a sticky fault when decimated samples stop.
module snr_measure_sequencer #(
    parameter int SNR_WIDTH      = 8,
    parameter int SETTLE_SAMPLES = 1024,
    parameter int CAL_SAMPLES    = 4096,
    parameter int UPDATE_LOG2    = 10,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int AUTO_START     = 1
) (
    input  logic                 AUD_BCLK,
    input  logic                 rst_n,
    input  logic                 cal_req_async,
    input  logic                 sample_valid,
    input  logic                 snr_valid,
    input  logic [SNR_WIDTH-1:0] snr_db,
    output logic                 quiet_period,
    output logic [SNR_WIDTH-1:0] snr_out,
    output logic                 snr_out_valid,
    output logic                 calibrated,
    output logic                 fault,
    output logic [2:0]           state_dbg
);
    typedef enum logic [2:0] {IDLE = 3'd0, SETTLE = 3'd1, CAL = 3'd2, MEAS = 3'd3, FAULT = 3'd4} state_t;
    localparam int MAXS = SETTLE_SAMPLES > CAL_SAMPLES ? SETTLE_SAMPLES : CAL_SAMPLES;
    localparam int CW = $clog2(MAXS + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = SNR_WIDTH + UPDATE_LOG2;
    localparam int BW = UPDATE_LOG2 + 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_SAMPLES - 1);
    localparam logic [CW-1:0] CAL_LAST    = CW'(CAL_SAMPLES - 1);
    localparam logic [WW-1:0] WD_LIMIT    = WW'(TIMEOUT_CYCLES);
    localparam logic [BW-1:0] BLK_LAST    = BW'((1 << UPDATE_LOG2) - 1);
    state_t                 state_q, state_d;
    logic [2:0]             sync_q, sync_d;
    logic                   started_q, started_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WW-1:0]          wd_q, wd_d, wd_inc;
    logic [AW-1:0]          acc_q, acc_d, acc_sum;
    logic [BW-1:0]          blk_q, blk_d;
    logic [SNR_WIDTH-1:0]   snr_out_q, snr_out_d;
    logic                   snr_out_valid_q, snr_out_valid_d;
    logic                   calibrated_q, calibrated_d;
    logic                   fault_q, fault_d;
    logic                   start;
    always_comb begin
        sync_d          = {sync_q[1:0], cal_req_async};
        start           = sync_q[1] & ~sync_q[2];
        started_d       = 1'b1;
        state_d         = state_q;
        cnt_d           = cnt_q;
        wd_d            = wd_q;
        acc_d           = acc_q;
        blk_d           = blk_q;
        snr_out_d       = snr_out_q;
        snr_out_valid_d = 1'b0;
        calibrated_d    = calibrated_q;
        fault_d         = fault_q;
        acc_sum         = acc_q + AW'(snr_db);
        wd_inc          = sample_valid ? '0 : wd_q + WW'(1);
        if (start) begin
            state_d      = SETTLE;
            cnt_d        = '0;
            wd_d         = '0;
            acc_d        = '0;
            blk_d        = '0;
            calibrated_d = 1'b0;
            fault_d      = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (AUTO_START != 0 && !started_q) state_d = SETTLE;
                SETTLE: if (sample_valid) begin
                    cnt_d   = cnt_q == SETTLE_LAST ? '0 : cnt_q + CW'(1);
                    state_d = cnt_q == SETTLE_LAST ? CAL : SETTLE;
                end
                CAL: if (sample_valid) begin
                    cnt_d        = cnt_q == CAL_LAST ? '0 : cnt_q + CW'(1);
                    state_d      = cnt_q == CAL_LAST ? MEAS : CAL;
                    calibrated_d = cnt_q == CAL_LAST;
                end
                MEAS: if (snr_valid) begin
                    acc_d           = blk_q == BLK_LAST ? '0 : acc_sum;
                    blk_d           = blk_q == BLK_LAST ? '0 : blk_q + BW'(1);
                    snr_out_d       = blk_q == BLK_LAST ? SNR_WIDTH'(acc_sum >> UPDATE_LOG2) : snr_out_q;
                    snr_out_valid_d = blk_q == BLK_LAST;
                end
                default: ;
            endcase
            // Watchdog can only expire on a cycle without sample_valid, so it never races a terminal count
            if (state_q == SETTLE || state_q == CAL || state_q == MEAS) begin
                wd_d = wd_inc;
                if (wd_inc == WD_LIMIT) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                end
            end
        end
    end
    always_ff @(posedge AUD_BCLK) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            sync_q          <= '0;
            started_q       <= 1'b0;
            cnt_q           <= '0;
            wd_q            <= '0;
            acc_q           <= '0;
            blk_q           <= '0;
            snr_out_q       <= '0;
            snr_out_valid_q <= 1'b0;
            calibrated_q    <= 1'b0;
            fault_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            sync_q          <= sync_d;
            started_q       <= started_d;
            cnt_q           <= cnt_d;
            wd_q            <= wd_d;
            acc_q           <= acc_d;
            blk_q           <= blk_d;
            snr_out_q       <= snr_out_d;
            snr_out_valid_q <= snr_out_valid_d;
            calibrated_q    <= calibrated_d;
            fault_q         <= fault_d;
        end
    end
    assign quiet_period  = state_q == CAL;
    assign state_dbg     = state_q;
    assign snr_out       = snr_out_q;
    assign snr_out_valid = snr_out_valid_q;
    assign calibrated    = calibrated_q;
    assign fault         = fault_q;
endmodule

// File: tb/tb_snr_measure_sequencer.sv
// tb_snr_measure_sequencer: scenario tasks against a pulse-count / running-sum reference model.
module tb_snr_measure_sequencer;
    localparam int SET = 4, CALN = 8, L2 = 2, TO = 20, BLK = 1 << L2;
    logic       clk = 1'b0, rst_n = 1'b0, cal_req = 1'b0, cal_req0 = 1'b0;
    logic       sample_valid = 1'b0, snr_valid = 1'b0;
    logic [7:0] snr_db = '0;
    logic       quiet, ov, cal, flt, quiet0, ov0, cal0, flt0;
    logic [7:0] sout, sout0;
    logic [2:0] st, st0;
    int         checks = 0, errors = 0;
    int         exp_out = 0;
    int         blkv[BLK];
    always #5 clk = ~clk;
    snr_measure_sequencer #(.SNR_WIDTH(8), .SETTLE_SAMPLES(SET), .CAL_SAMPLES(CALN), .UPDATE_LOG2(L2),
        .TIMEOUT_CYCLES(TO), .AUTO_START(1)) dut (
        .AUD_BCLK(clk), .rst_n(rst_n), .cal_req_async(cal_req), .sample_valid(sample_valid),
        .snr_valid(snr_valid), .snr_db(snr_db), .quiet_period(quiet), .snr_out(sout),
        .snr_out_valid(ov), .calibrated(cal), .fault(flt), .state_dbg(st));
    snr_measure_sequencer #(.SNR_WIDTH(8), .SETTLE_SAMPLES(SET), .CAL_SAMPLES(CALN), .UPDATE_LOG2(L2),
        .TIMEOUT_CYCLES(TO), .AUTO_START(0)) dut0 (
        .AUD_BCLK(clk), .rst_n(rst_n), .cal_req_async(cal_req0), .sample_valid(sample_valid),
        .snr_valid(snr_valid), .snr_db(snr_db), .quiet_period(quiet0), .snr_out(sout0),
        .snr_out_valid(ov0), .calibrated(cal0), .fault(flt0), .state_dbg(st0));
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic pulses(input int n);
        repeat (n) begin
            sample_valid = 1'b1;
            cyc(1);
            sample_valid = 1'b0;
            cyc($urandom_range(0, 6));
        end
    endtask
    // Expected phase after i pulses: first SET-1 settle, then CAL, then MEAS from pulse SET+CALN on
    task automatic run_session(input string tag);
        logic [2:0] es;
        for (int i = 1; i <= SET + CALN; i++) begin
            sample_valid = 1'b1;
            cyc(1);
            sample_valid = 1'b0;
            es = i < SET ? 3'd1 : i < SET + CALN ? 3'd2 : 3'd3;
            checks++;
            if (st !== es || quiet !== (es == 3'd2) || cal !== (es == 3'd3)) begin
                errors++;
                $display("FAIL %s pulse %0d: state %0d quiet %0b cal %0b, want state %0d quiet %0b cal %0b",
                         tag, i, st, quiet, cal, es, es == 3'd2, es == 3'd3);
            end
            cyc($urandom_range(0, 6));
        end
    endtask
    task automatic meas_block(input string tag);
        int sum = 0;
        for (int k = 0; k < BLK; k++) begin
            snr_db = 8'(blkv[k]);
            snr_valid = 1'b1;
            sample_valid = 1'b1;
            cyc(1);
            snr_valid = 1'b0;
            sample_valid = 1'b0;
            sum += blkv[k];
            checks++;
            if (ov !== (k == BLK - 1)) begin
                errors++;
                $display("FAIL %s valid strobe %0d: got %0b want %0b", tag, k, ov, k == BLK - 1);
            end
            if (k == BLK - 1) begin
                exp_out = sum / BLK;
                checks++;
                if (sout !== 8'(exp_out)) begin
                    errors++;
                    $display("FAIL %s snr_out: got %0d want %0d", tag, sout, exp_out);
                end
            end
            cyc(1);
            checks++;
            if (ov !== 1'b0) begin
                errors++;
                $display("FAIL %s valid not one-cycle: got %0b want 0", tag, ov);
            end
        end
    endtask
    task automatic test_reset;
        cyc(3);
        checks++;
        if ({quiet, sout, ov, cal, flt, st, quiet0, sout0, ov0, cal0, flt0, st0} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got %h/%h want 0", {quiet, sout, ov, cal, flt, st},
                     {quiet0, sout0, ov0, cal0, flt0, st0});
        end
        rst_n = 1'b1;
        cyc(1);
        checks++;
        if (st !== 3'd1 || st0 !== 3'd0) begin
            errors++;
            $display("FAIL autostart cycle1: state %0d/%0d want 1/0", st, st0);
        end
        run_session("boot");
    endtask
    task automatic test_averaging;
        blkv = '{10, 20, 30, 41};
        meas_block("avg_directed");
        blkv = '{7, 7, 7, 7};
        meas_block("avg_sevens");
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < BLK; k++) blkv[k] = $urandom_range(0, 255);
            meas_block("avg_random");
        end
    endtask
    task automatic test_restart_cal;
        cal_req = 1'b1;
        cyc(2);
        checks++;
        if (st !== 3'd3) begin
            errors++;
            $display("FAIL restart latency early: state %0d want 3", st);
        end
        cyc(1);
        checks++;
        if (st !== 3'd1 || quiet !== 1'b0 || cal !== 1'b0 || sout !== 8'(exp_out)) begin
            errors++;
            $display("FAIL restart from meas: state %0d quiet %0b cal %0b out %0d want 1 0 0 %0d",
                     st, quiet, cal, sout, exp_out);
        end
        cal_req = 1'b0;
        pulses(SET + 3);
        checks++;
        if (st !== 3'd2 || quiet !== 1'b1) begin
            errors++;
            $display("FAIL mid cal: state %0d quiet %0b want 2 1", st, quiet);
        end
        cal_req = 1'b1;
        cyc(3);
        checks++;
        if (st !== 3'd1 || quiet !== 1'b0 || cal !== 1'b0 || sout !== 8'(exp_out)) begin
            errors++;
            $display("FAIL restart mid cal: state %0d quiet %0b cal %0b out %0d want 1 0 0 %0d",
                     st, quiet, cal, sout, exp_out);
        end
        cal_req = 1'b0;
        run_session("recal");
    endtask
    task automatic test_simultaneous;
        cal_req = 1'b1;
        cyc(3);
        cal_req = 1'b0;
        pulses(SET - 1);
        cal_req = 1'b1;
        cyc(2);
        sample_valid = 1'b1;
        cyc(1);
        sample_valid = 1'b0;
        checks++;
        if (st !== 3'd1 || quiet !== 1'b0) begin
            errors++;
            $display("FAIL start vs terminal count: state %0d quiet %0b want 1 0", st, quiet);
        end
        cal_req = 1'b0;
        run_session("after_simul");
    endtask
    task automatic test_watchdog;
        sample_valid = 1'b1;
        cyc(1);
        sample_valid = 1'b0;
        cyc(TO - 1);
        checks++;
        if (st !== 3'd3 || flt !== 1'b0) begin
            errors++;
            $display("FAIL watchdog early: state %0d fault %0b want 3 0", st, flt);
        end
        cyc(1);
        checks++;
        if (st !== 3'd4 || flt !== 1'b1 || quiet !== 1'b0) begin
            errors++;
            $display("FAIL watchdog trip: state %0d fault %0b quiet %0b want 4 1 0", st, flt, quiet);
        end
        for (int k = 0; k < 2 * BLK; k++) begin
            snr_db = 8'($urandom_range(0, 255));
            snr_valid = 1'b1;
            cyc(1);
            snr_valid = 1'b0;
            checks++;
            if (ov !== 1'b0 || sout !== 8'(exp_out) || st !== 3'd4) begin
                errors++;
                $display("FAIL fault ignores snr: valid %0b out %0d state %0d want 0 %0d 4", ov, sout, st, exp_out);
            end
        end
        cal_req = 1'b1;
        cyc(3);
        checks++;
        if (st !== 3'd1 || flt !== 1'b0 || cal !== 1'b0) begin
            errors++;
            $display("FAIL fault clear: state %0d fault %0b cal %0b want 1 0 0", st, flt, cal);
        end
        cal_req = 1'b0;
        cyc(2);
    endtask
    task automatic test_autostart_off;
        checks++;
        if (st0 !== 3'd0 || {quiet0, ov0, cal0, flt0, sout0} !== '0) begin
            errors++;
            $display("FAIL no autostart idle: state %0d outs %h want 0 0", st0, {quiet0, ov0, cal0, flt0, sout0});
        end
        cal_req0 = 1'b1;
        cyc(2);
        checks++;
        if (st0 !== 3'd0) begin
            errors++;
            $display("FAIL no autostart latency: state %0d want 0", st0);
        end
        cyc(1);
        checks++;
        if (st0 !== 3'd1) begin
            errors++;
            $display("FAIL no autostart start: state %0d want 1", st0);
        end
        pulses(SET - 1);
        checks++;
        if (st0 !== 3'd1) begin
            errors++;
            $display("FAIL held level settle: state %0d want 1", st0);
        end
        pulses(1);
        checks++;
        if (st0 !== 3'd2 || quiet0 !== 1'b1) begin
            errors++;
            $display("FAIL held level no restart: state %0d quiet %0b want 2 1", st0, quiet0);
        end
        cal_req0 = 1'b0;
    endtask
    initial begin
        test_reset;
        test_averaging;
        test_restart_cal;
        test_simultaneous;
        test_watchdog;
        test_autostart_off;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
